// File: rtl/shift_reg_sequencer.sv
// Command sequencer for the 4-bit shifting register: turns load/shift/rotate
// commands into cycle-by-cycle mode, serial-input and parallel-data controls.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
  input  logic             abort,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic             s_in,
  output logic [WIDTH-1:0] d_out,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_SHIFT  = 2'b10,
    ST_FINISH = 2'b11
  } state_e;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SHR    = 2'b10;
  localparam logic [1:0] OP_ROL    = 2'b11;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sin_q, sin_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  // State and command registers; reset overrides everything including abort.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      cnt_q    <= '0;
      sin_q    <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sin_q    <= sin_d;
      data_q   <= data_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state and register control decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    sin_d     = sin_q;
    data_d    = data_q;
    done_d    = 1'b0;
    result_d  = result_q;
    cmd_ready = 1'b0;
    mode      = MODE_HOLD;
    s_in      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = reset_n;
        if (cmd_valid && reset_n) begin
          op_d  = cmd_op;
          cnt_d = cmd_count;
          sin_d = cmd_sin;
          if (cmd_op == OP_LOAD) begin
            data_d  = cmd_data;
            state_d = ST_LOAD;
          end else if (cmd_count != '0) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_LOAD: begin
        mode    = MODE_LOAD;
        state_d = abort ? ST_IDLE : ST_FINISH;
      end
      ST_SHIFT: begin
        mode  = (op_q == OP_SHR) ? MODE_SHR : MODE_SHL;
        // Rotate feeds the MSB straight back into the serial input.
        s_in  = (op_q == OP_ROL) ? q[WIDTH-1] : sin_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d   = 1'b1;
        result_d = q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign d_out  = data_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench for shift_reg_sequencer with a behavioural 4-bit
// shifting register closing the q feedback loop.
module tb_shift_reg_sequencer;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_sin;
  logic             abort;
  logic [WIDTH-1:0] q_reg = '0;
  logic [1:0]       mode;
  logic             s_in;
  logic [WIDTH-1:0] d_out;
  logic             done;
  logic [WIDTH-1:0] result;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
    bit               want;
    int               acc;
  } exp_t;

  exp_t stim[$];
  exp_t pend[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   m01   = 0;
  int   m10   = 0;
  int   m11   = 0;
  bit   b2b_seen = 1'b0;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .cmd_data  (cmd_data),
    .cmd_sin   (cmd_sin),
    .abort     (abort),
    .q         (q_reg),
    .mode      (mode),
    .s_in      (s_in),
    .d_out     (d_out),
    .done      (done),
    .result    (result)
  );

  // Datapath model: 01 shift left (s_in into LSB), 10 shift right (s_in into MSB), 11 load.
  always @(posedge clk) begin
    case (mode)
      2'b01:   q_reg <= {q_reg[WIDTH-2:0], s_in};
      2'b10:   q_reg <= {s_in, q_reg[WIDTH-1:1]};
      2'b11:   q_reg <= d_out;
      default: q_reg <= q_reg;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pairs accepts with queued expectations and checks each done.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done === 1'b1) begin
      if (pend.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = pend.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && reset_n === 1'b1) begin
      if (done === 1'b1) b2b_seen = 1'b1;
      if (stim.size() == 0) begin
        chk("unexpected_accept", 32'(cmd_valid), 32'd0);
      end else begin
        e = stim.pop_front();
        e.acc = cyc + 1;
        if (e.want) pend.push_back(e);
      end
    end
    if (mode === 2'b01) m01++;
    if (mode === 2'b10) m10++;
    if (mode === 2'b11) m11++;
  end

  task automatic clear_counts();
    m01 = 0;
    m10 = 0;
    m11 = 0;
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] cnt,
                      input logic [WIDTH-1:0] data, input logic sin,
                      input logic [WIDTH-1:0] res, input int lat, input bit want);
    exp_t e;
    bit   ok;
    e.res  = res;
    e.lat  = lat;
    e.want = want;
    e.acc  = 0;
    stim.push_back(e);
    cmd_op    = op;
    cmd_count = cnt;
    cmd_data  = data;
    cmd_sin   = sin;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (cmd_ready === 1'b1);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("accept_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = (pend.size() == 0 && stim.size() == 0);
    end
    chk("done_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rot_sin;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    cmd_data  = '0;
    cmd_sin   = 1'b0;
    abort     = 1'b0;
    reset_n   = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_s_in", 32'(s_in), 32'd0);
    chk("rst_d_out", 32'(d_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;

    // Load 1011
    clear_counts();
    send(2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011, 3, 1'b1);
    wait_done();
    chk("load_mode_cycles", 32'(m11), 32'd1);
    chk("load_q", 32'(q_reg), 32'b1011);

    // Shift right 2 with sin 0: 1011 -> 0101 -> 0010
    clear_counts();
    send(2'b10, 3'd2, 4'b0000, 1'b0, 4'b0010, 4, 1'b1);
    wait_done();
    chk("shr_mode_cycles", 32'(m10), 32'd2);
    chk("d_out_holds", 32'(d_out), 32'b1011);

    // Rotate left 3 from 1001 -> 0011 -> 0110 -> 1100, then 4 more returns 1100
    send(2'b00, 3'd0, 4'b1001, 1'b0, 4'b1001, 3, 1'b1);
    wait_done();
    send(2'b11, 3'd3, 4'b0000, 1'b0, 4'b1100, 5, 1'b1);
    rot_sin = 3'b100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rot_s_in", 32'(s_in), 32'(rot_sin[2-i]));
      @(posedge clk);
      #1;
    end
    wait_done();
    send(2'b11, 3'd4, 4'b0000, 1'b0, 4'b1100, 6, 1'b1);
    wait_done();
    chk("rot4_q", 32'(q_reg), 32'b1100);

    // Count 0 shift left: register untouched
    clear_counts();
    send(2'b01, 3'd0, 4'b0000, 1'b1, 4'b1100, 2, 1'b1);
    wait_done();
    chk("cnt0_mode_cycles", 32'(m01 + m10 + m11), 32'd0);
    chk("cnt0_q", 32'(q_reg), 32'b1100);

    // Abort in 2nd SHIFT cycle of a shift-left-5 with sin 1: 1100 -> 1001 -> 0011
    clear_counts();
    send(2'b01, 3'd5, 4'b0000, 1'b1, 4'b0000, 0, 1'b0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_mode", 32'(mode), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_shifts", 32'(m01), 32'd2);
    chk("abort_q", 32'(q_reg), 32'b0011);
    chk("abort_result", 32'(result), 32'b1100);

    // Reset during SHIFT
    send(2'b10, 3'd4, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_s_in", 32'(s_in), 32'd0);
    chk("midrst_d_out", 32'(d_out), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_ready_after", 32'(cmd_ready), 32'd1);

    // Back-to-back: load 0110, then shift left 1 with sin 1 -> 1101
    b2b_seen = 1'b0;
    send(2'b00, 3'd0, 4'b0110, 1'b0, 4'b0110, 3, 1'b1);
    send(2'b01, 3'd1, 4'b0000, 1'b1, 4'b1101, 3, 1'b1);
    wait_done();
    chk("b2b_accept_on_done", 32'(b2b_seen), 32'd1);
    chk("b2b_q", 32'(q_reg), 32'b1101);

    chk("scoreboard_drained", 32'(pend.size() + stim.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
